stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Debounced front-panel controller with PAUSED/RUN/ADJUST mode FSM.
// Revision : 1.0 - initial release
// ============================================================================

module stopwatch_ctrl_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   input  logic vld_i,
   output logic level_o,
   output logic press_o
);

   localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic               meta_q;
   logic               sync_q;
   logic               level_q;
   logic               level_d;
   logic               prev_q;
   logic               arm_q;
   logic               arm_d;
   logic [c_CNT_W-1:0] cnt_q;
   logic [c_CNT_W-1:0] cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         arm_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= raw_i;
         sync_q  <= meta_q;
         level_q <= level_d;
         prev_q  <= level_q;
         arm_q   <= arm_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q != level_q) begin
         if (cnt_q == c_CNT_MAX) begin
            level_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // A press is only honoured once the input has been seen released after
   // reset, so a button held through reset stays silent until re-pressed.
   assign arm_d   = arm_q | (vld_i & ~sync_q & ~level_q);
   assign level_o = level_q;
   assign press_o = level_q & ~prev_q & arm_q;

endmodule

module stopwatch_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_CYCLES    = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_pause,
   input  logic       btn_reset,
   input  logic       btn_sel,
   input  logic       btn_inc,
   input  logic       sw_adj,
   input  logic [4:0] min_l,
   input  logic [4:0] min_r,
   input  logic [4:0] sec_l,
   input  logic [4:0] sec_r,
   output logic       ctr_rst,
   output logic       paused,
   output logic       adj,
   output logic [1:0] adj_sel,
   output logic [3:0] adj_val,
   output logic       adj_we,
   output logic       blink
);

   localparam int c_BLK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [c_BLK_W-1:0] c_BLK_MAX = c_BLK_W'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_PAUSED = 2'd0,
      ST_RUN    = 2'd1,
      ST_ADJUST = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [1:0]         vld_q;
   logic [4:0]         raw_w;
   logic [4:0]         deb_level_w;
   logic [4:0]         deb_press_w;
   logic               unused_w;

   logic               ctr_rst_q, ctr_rst_d;
   logic               paused_q, paused_d;
   logic               adj_q, adj_d;
   logic [1:0]         adj_sel_q, adj_sel_d;
   logic [3:0]         adj_val_q, adj_val_d;
   logic               adj_we_q, adj_we_d;
   logic               sel_pend_q, sel_pend_d;
   logic               blink_q, blink_d;
   logic [c_BLK_W-1:0] blk_cnt_q, blk_cnt_d;

   logic               pause_press_w;
   logic               reset_press_w;
   logic               sel_press_w;
   logic               inc_press_w;
   logic               adj_level_w;
   logic [4:0]         digit_w;
   logic [5:0]         limit_w;
   logic [5:0]         digit_inc_w;
   logic [3:0]         next_val_w;

   assign raw_w = {sw_adj, btn_inc, btn_sel, btn_reset, btn_pause};

   // Marks the synchronizer as holding real samples rather than reset zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 2'b00;
      end else begin
         vld_q <= {vld_q[0], 1'b1};
      end
   end

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_cond
         stopwatch_ctrl_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (raw_w[gi]),
            .vld_i   (vld_q[1]),
            .level_o (deb_level_w[gi]),
            .press_o (deb_press_w[gi])
         );
      end
   endgenerate

   assign pause_press_w = deb_press_w[0];
   assign reset_press_w = deb_press_w[1];
   assign sel_press_w   = deb_press_w[2];
   assign inc_press_w   = deb_press_w[3];
   assign adj_level_w   = deb_level_w[4];
   assign unused_w      = ^{deb_level_w[3:0], deb_press_w[4]};

   always_comb begin
      digit_w = min_l;
      unique case (adj_sel_q)
         2'd0: digit_w = min_l;
         2'd1: digit_w = min_r;
         2'd2: digit_w = sec_l;
         2'd3: digit_w = sec_r;
         default: digit_w = min_l;
      endcase
   end

   // Tens-of-seconds wraps at 6; the others at 10. Out-of-range inputs load 0.
   assign limit_w     = (adj_sel_q == 2'd2) ? 6'd6 : 6'd10;
   assign digit_inc_w = {1'b0, digit_w} + 6'd1;
   assign next_val_w  = (digit_inc_w < limit_w) ? digit_inc_w[3:0] : 4'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_PAUSED;
         ctr_rst_q  <= 1'b0;
         paused_q   <= 1'b1;
         adj_q      <= 1'b0;
         adj_sel_q  <= 2'd0;
         adj_val_q  <= 4'd0;
         adj_we_q   <= 1'b0;
         sel_pend_q <= 1'b0;
         blink_q    <= 1'b0;
         blk_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         ctr_rst_q  <= ctr_rst_d;
         paused_q   <= paused_d;
         adj_q      <= adj_d;
         adj_sel_q  <= adj_sel_d;
         adj_val_q  <= adj_val_d;
         adj_we_q   <= adj_we_d;
         sel_pend_q <= sel_pend_d;
         blink_q    <= blink_d;
         blk_cnt_q  <= blk_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ctr_rst_d  = 1'b0;
      adj_sel_d  = adj_sel_q;
      adj_val_d  = adj_val_q;
      adj_we_d   = 1'b0;
      sel_pend_d = 1'b0;
      unique case (state_q)
         ST_PAUSED, ST_RUN: begin
            if (reset_press_w) begin
               ctr_rst_d = 1'b1;
               state_d   = ST_PAUSED;
            end else if (adj_level_w) begin
               state_d   = ST_ADJUST;
               adj_sel_d = 2'd0;
            end else if (pause_press_w) begin
               state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
            end
         end
         ST_ADJUST: begin
            // A sel that coincided with an inc advances one cycle late so the
            // cursor stays on the written digit while adj_we is high.
            if (sel_pend_q) begin
               adj_sel_d = adj_sel_q + 2'd1;
            end
            if (reset_press_w) begin
               ctr_rst_d = 1'b1;
               adj_sel_d = 2'd0;
            end else if (!adj_level_w) begin
               state_d = ST_PAUSED;
            end else begin
               if (inc_press_w) begin
                  adj_val_d  = next_val_w;
                  adj_we_d   = 1'b1;
                  sel_pend_d = sel_press_w;
               end else if (sel_press_w) begin
                  adj_sel_d = adj_sel_q + 2'd1;
               end
            end
         end
         default: state_d = ST_PAUSED;
      endcase
      paused_d = (state_d != ST_RUN);
      adj_d    = (state_d == ST_ADJUST);
   end

   always_comb begin
      blk_cnt_d = '0;
      blink_d   = 1'b0;
      if ((state_q == ST_ADJUST) && (state_d == ST_ADJUST)) begin
         blink_d = blink_q;
         if (blk_cnt_q == c_BLK_MAX) begin
            blink_d = ~blink_q;
         end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
         end
      end
   end

   assign ctr_rst = ctr_rst_q;
   assign paused  = paused_q;
   assign adj     = adj_q;
   assign adj_sel = adj_sel_q;
   assign adj_val = adj_val_q;
   assign adj_we  = adj_we_q;
   assign blink   = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Directed vector bench for stopwatch_ctrl (debounce 4, blink 8).
// Revision : 1.0 - initial release
// ============================================================================

module tb_stopwatch_ctrl;

   localparam int c_DB = 4;
   localparam int c_BL = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_pause = 1'b0, btn_reset = 1'b0, btn_sel = 1'b0, btn_inc = 1'b0;
   logic       sw_adj = 1'b0;
   logic [4:0] min_l = '0, min_r = '0, sec_l = '0, sec_r = '0;
   logic       ctr_rst, paused, adj, adj_we, blink;
   logic [1:0] adj_sel;
   logic [3:0] adj_val;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       p, r, s, i, sw;
      logic [4:0] ml, mr, sl, sr;
      int         n_we, n_rst;
      logic [3:0] val;
      logic [1:0] wsel;
      logic       pa, ad;
      logic [1:0] sf;
   } vec_t;

   vec_t vq[$];

   stopwatch_ctrl #(
      .DEBOUNCE_CYCLES(c_DB),
      .BLINK_CYCLES   (c_BL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_pause (btn_pause),
      .btn_reset (btn_reset),
      .btn_sel   (btn_sel),
      .btn_inc   (btn_inc),
      .sw_adj    (sw_adj),
      .min_l     (min_l),
      .min_r     (min_r),
      .sec_l     (sec_l),
      .sec_r     (sec_r),
      .ctr_rst   (ctr_rst),
      .paused    (paused),
      .adj       (adj),
      .adj_sel   (adj_sel),
      .adj_val   (adj_val),
      .adj_we    (adj_we),
      .blink     (blink)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic p, r, s, i, sw,
                               input logic [4:0] ml, mr, sl, sr,
                               input int nwe, nrst,
                               input logic [3:0] val, input logic [1:0] wsel,
                               input logic pa, ad, input logic [1:0] sf);
      vec_t v;
      v.p = p; v.r = r; v.s = s; v.i = i; v.sw = sw;
      v.ml = ml; v.mr = mr; v.sl = sl; v.sr = sr;
      v.n_we = nwe; v.n_rst = nrst; v.val = val; v.wsel = wsel;
      v.pa = pa; v.ad = ad; v.sf = sf;
      return v;
   endfunction

   initial begin
      int nstr;
      int nrun;
      int k;

      //            p r s i sw  ml  mr sl sr  we rst val ws  pa ad sf
      vq.push_back(mk(1,0,0,0,0,  0,  0, 0, 0,  0, 0,  0, 0,  1, 0, 0)); // back to PAUSED
      vq.push_back(mk(1,0,0,0,0,  0,  0, 0, 0,  0, 0,  0, 0,  0, 0, 0)); // RUN
      vq.push_back(mk(0,0,0,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 0)); // enter ADJUST
      vq.push_back(mk(1,0,0,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 0)); // pause ignored
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 1));
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 2));
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 3));
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 0)); // wrap
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 1));
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 2));
      vq.push_back(mk(0,0,0,1,1,  0,  0, 5, 0,  1, 0,  0, 2,  1, 1, 2)); // sec_l 5->0
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 3));
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 0));
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 1));
      vq.push_back(mk(0,0,0,1,1,  0,  9, 0, 0,  1, 0,  0, 1,  1, 1, 1)); // min_r 9->0
      vq.push_back(mk(0,0,0,1,1,  0,  3, 0, 0,  1, 0,  4, 1,  1, 1, 1)); // min_r 3->4
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 2));
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 3));
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 0));
      vq.push_back(mk(0,0,0,1,1, 17,  0, 0, 0,  1, 0,  0, 0,  1, 1, 0)); // out of range
      vq.push_back(mk(0,0,1,1,1,  2,  0, 0, 0,  1, 0,  3, 0,  1, 1, 1)); // inc+sel
      vq.push_back(mk(0,1,0,1,1,  2,  0, 0, 0,  0, 1,  0, 0,  1, 1, 0)); // reset+inc
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 1));
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 2));
      vq.push_back(mk(0,0,0,1,1,  0,  0, 4, 0,  1, 0,  5, 2,  1, 1, 2)); // sec_l 4->5
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 3));
      vq.push_back(mk(0,0,0,1,1,  0,  0, 0, 7,  1, 0,  8, 3,  1, 1, 3)); // sec_r 7->8
      vq.push_back(mk(0,0,1,0,1,  0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 0));
      vq.push_back(mk(0,0,0,0,0,  0,  0, 0, 0,  0, 0,  0, 0,  1, 0, 0)); // exit ADJUST
      vq.push_back(mk(1,0,0,0,0,  0,  0, 0, 0,  0, 0,  0, 0,  0, 0, 0)); // RUN
      vq.push_back(mk(0,1,0,0,0,  0,  0, 0, 0,  0, 1,  0, 0,  1, 0, 0)); // reset in RUN

      // Reset with pause held: reset values, then no press from the held button.
      btn_pause = 1'b1;
      repeat (3) tick();
      chk("rst_paused", paused, 1);
      chk("rst_adj", adj, 0);
      chk("rst_adj_sel", adj_sel, 0);
      chk("rst_adj_val", adj_val, 0);
      chk("rst_adj_we", adj_we, 0);
      chk("rst_ctr_rst", ctr_rst, 0);
      chk("rst_blink", blink, 0);
      rst_n = 1'b1;
      nstr = 0;
      nrun = 0;
      repeat (20) begin
         tick();
         if (ctr_rst || adj_we) nstr++;
         if (!paused) nrun++;
      end
      chk("held_pause_run_cycles", nrun, 0);
      chk("held_pause_strobes", nstr, 0);
      btn_pause = 1'b0;
      repeat (12) tick();

      // Pause press latency: output changes on the 7th edge.
      btn_pause = 1'b1;
      repeat (6) tick();
      chk("pause_lat_before", paused, 1);
      tick();
      chk("pause_lat_after", paused, 0);
      repeat (3) tick();
      btn_pause = 1'b0;
      repeat (12) tick();

      // Three-cycle glitch must be rejected.
      btn_pause = 1'b1;
      repeat (3) tick();
      btn_pause = 1'b0;
      repeat (12) tick();
      chk("glitch_paused", paused, 0);

      foreach (vq[idx]) begin
         int         nwe;
         int         nrst;
         logic [3:0] wval;
         logic [1:0] wsel;
         nwe = 0; nrst = 0; wval = '0; wsel = '0;
         btn_pause = vq[idx].p; btn_reset = vq[idx].r;
         btn_sel = vq[idx].s; btn_inc = vq[idx].i; sw_adj = vq[idx].sw;
         min_l = vq[idx].ml; min_r = vq[idx].mr;
         sec_l = vq[idx].sl; sec_r = vq[idx].sr;
         for (int c = 0; c < 22; c++) begin
            if (c == 10) begin
               btn_pause = 1'b0; btn_reset = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
            end
            tick();
            if (adj_we) begin
               nwe++;
               wval = adj_val;
               wsel = adj_sel;
            end
            if (ctr_rst) nrst++;
         end
         chk($sformatf("v%0d_we_count", idx), nwe, vq[idx].n_we);
         chk($sformatf("v%0d_rst_count", idx), nrst, vq[idx].n_rst);
         if (vq[idx].n_we > 0) begin
            chk($sformatf("v%0d_we_val", idx), wval, vq[idx].val);
            chk($sformatf("v%0d_we_sel", idx), wsel, vq[idx].wsel);
         end
         chk($sformatf("v%0d_paused", idx), paused, vq[idx].pa);
         chk($sformatf("v%0d_adj", idx), adj, vq[idx].ad);
         chk($sformatf("v%0d_adj_sel", idx), adj_sel, vq[idx].sf);
      end
      min_l = '0; min_r = '0; sec_l = '0; sec_r = '0;

      // Adjust entry latency and blink period, then exit while blink is high.
      sw_adj = 1'b1;
      repeat (6) tick();
      chk("adj_entry_before", adj, 0);
      tick();
      chk("adj_entry_after", adj, 1);
      chk("adj_entry_blink", blink, 0);
      k = 0;
      while (!blink && k < 20) begin tick(); k++; end
      chk("blink_first_rise", k, c_BL);
      k = 0;
      while (blink && k < 20) begin tick(); k++; end
      chk("blink_fall", k, c_BL);
      k = 0;
      while (!blink && k < 20) begin tick(); k++; end
      chk("blink_second_rise", k, c_BL);
      sw_adj = 1'b0;
      repeat (6) tick();
      chk("adj_exit_before", adj, 1);
      tick();
      chk("adj_exit_adj", adj, 0);
      chk("adj_exit_paused", paused, 1);
      chk("adj_exit_blink", blink, 0);
      repeat (5) tick();

      // Asynchronous reset mid-cycle with reset button held through it.
      btn_reset = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_adj_val", adj_val, 0);
      chk("async_rst_paused", paused, 1);
      repeat (2) tick();
      rst_n = 1'b1;
      nstr = 0;
      repeat (15) begin
         tick();
         if (ctr_rst) nstr++;
      end
      chk("held_reset_no_pulse", nstr, 0);
      btn_reset = 1'b0;
      repeat (12) tick();
      btn_reset = 1'b1;
      nstr = 0;
      repeat (12) begin
         tick();
         if (ctr_rst) nstr++;
      end
      chk("repress_reset_pulse", nstr, 1);
      btn_reset = 1'b0;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
